// File: rtl/cim_ctrl_seq.sv
// CIM core CSR file with a two-cycle-per-word SRAM/eDRAM copy sequencer.
// Optional PERF busy-cycle counter at 0x40 is built when CIM_CTRL_SEQ_PERF_CNT_EN is defined.
module cim_ctrl_seq #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_USER_REGS  = 4,
    parameter int USER_REG_WIDTH = 32
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      reg_valid_i,
    input  logic                                      reg_write_i,
    input  logic [7:0]                                reg_addr_i,
    input  logic [31:0]                               reg_wdata_i,
    input  logic [3:0]                                reg_wstrb_i,
    output logic [31:0]                               reg_rdata_o,
    output logic                                      reg_error_o,
    output logic                                      reg_ready_o,
    output logic                                      mem_mux_o,
    output logic [NUM_USER_REGS*USER_REG_WIDTH-1:0]   user_regs_o,
    output logic                                      sram_req_o,
    output logic                                      sram_we_o,
    output logic [ADDR_WIDTH-1:0]                     sram_addr_o,
    output logic [DATA_WIDTH/8-1:0]                   sram_be_o,
    output logic [DATA_WIDTH-1:0]                     sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]                     sram_rdata_i,
    output logic                                      edram_req_o,
    output logic                                      edram_we_o,
    output logic [ADDR_WIDTH-1:0]                     edram_addr_o,
    output logic [DATA_WIDTH/8-1:0]                   edram_be_o,
    output logic [DATA_WIDTH-1:0]                     edram_wdata_o,
    input  logic [DATA_WIDTH-1:0]                     edram_rdata_i,
    output logic                                      irq_o
);
    localparam logic [5:0] W_CTRL   = 6'd0;
    localparam logic [5:0] W_STATUS = 6'd1;
    localparam logic [5:0] W_SRC    = 6'd2;
    localparam logic [5:0] W_DST    = 6'd3;
    localparam logic [5:0] W_LEN    = 6'd4;
    localparam int         USER0    = 5;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    state_t state_q, state_d;

    logic                  mux_q, mux_d, dir_q, dir_d, irq_en_q, irq_en_d;
    logic                  done_q, done_d, err_q, err_d, irq_q, irq_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH-1:0] run_src_q, run_src_d, run_dst_q, run_dst_d;
    logic [15:0]           run_len_q, run_len_d, idx_q, idx_d;
    logic                  run_dir_q, run_dir_d;

    logic [5:0] widx;
    logic       wr_en, busy, start_req, start_ok, cfg_wr, err_set, last_word;
    logic       unused_addr_bits;

    assign widx             = reg_addr_i[7:2];
    assign unused_addr_bits = &{1'b0, reg_addr_i[1:0]};
    assign wr_en            = reg_valid_i & reg_write_i;
    assign busy             = (state_q == S_RD) || (state_q == S_WR);
    assign start_req        = wr_en && (widx == W_CTRL) && reg_wstrb_i[0] && reg_wdata_i[0];
    // FIN already reports idle, so a start landing there is accepted like one in IDLE.
    assign start_ok         = start_req && !busy;
    assign cfg_wr           = wr_en && (widx == W_SRC || widx == W_DST || widx == W_LEN);
    assign err_set          = busy && (start_req || cfg_wr);
    assign last_word        = (idx_q == run_len_q - 16'd1);

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start_ok) state_d = (len_q != 16'd0) ? S_RD : S_FIN;
            end
            S_RD:    state_d = S_WR;
            S_WR:    state_d = last_word ? S_FIN : S_RD;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: memory port outputs; the port not being addressed stays all-zero
    always_comb begin
        sram_req_o    = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = '0;
        sram_be_o     = '0;
        sram_wdata_o  = '0;
        edram_req_o   = 1'b0;
        edram_we_o    = 1'b0;
        edram_addr_o  = '0;
        edram_be_o    = '0;
        edram_wdata_o = '0;
        if (state_q == S_RD) begin
            if (!run_dir_q) begin
                sram_req_o  = 1'b1;
                sram_addr_o = run_src_q + ADDR_WIDTH'(idx_q);
            end else begin
                edram_req_o  = 1'b1;
                edram_addr_o = run_src_q + ADDR_WIDTH'(idx_q);
            end
        end else if (state_q == S_WR) begin
            if (!run_dir_q) begin
                edram_req_o   = 1'b1;
                edram_we_o    = 1'b1;
                edram_be_o    = '1;
                edram_addr_o  = run_dst_q + ADDR_WIDTH'(idx_q);
                edram_wdata_o = sram_rdata_i;
            end else begin
                sram_req_o    = 1'b1;
                sram_we_o     = 1'b1;
                sram_be_o     = '1;
                sram_addr_o   = run_dst_q + ADDR_WIDTH'(idx_q);
                sram_wdata_o  = edram_rdata_i;
            end
        end
    end

    always_comb begin
        mux_d     = mux_q;
        dir_d     = dir_q;
        irq_en_d  = irq_en_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        run_src_d = run_src_q;
        run_dst_d = run_dst_q;
        run_len_d = run_len_q;
        run_dir_d = run_dir_q;
        idx_d     = idx_q;
        done_d    = done_q;
        err_d     = err_q;

        if (wr_en && widx == W_CTRL && reg_wstrb_i[0]) begin
            mux_d    = reg_wdata_i[1];
            dir_d    = reg_wdata_i[2];
            irq_en_d = reg_wdata_i[3];
        end
        if (wr_en && !busy) begin
            if (widx == W_SRC) src_d = ADDR_WIDTH'(merge(32'(src_q), reg_wdata_i, reg_wstrb_i));
            if (widx == W_DST) dst_d = ADDR_WIDTH'(merge(32'(dst_q), reg_wdata_i, reg_wstrb_i));
            if (widx == W_LEN) len_d = 16'(merge(32'(len_q), reg_wdata_i, reg_wstrb_i));
        end

        // Clears are applied first so a simultaneous set always wins.
        if (wr_en && widx == W_STATUS && reg_wstrb_i[0]) begin
            if (reg_wdata_i[1]) done_d = 1'b0;
            if (reg_wdata_i[2]) err_d  = 1'b0;
        end
        if (state_q == S_FIN) done_d = 1'b1;
        if (err_set)          err_d  = 1'b1;

        if (start_ok) begin
            run_src_d = src_q;
            run_dst_d = dst_q;
            run_len_d = len_q;
            run_dir_d = dir_q;
            idx_d     = 16'd0;
        end else if (state_q == S_WR && !last_word) begin
            idx_d = idx_q + 16'd1;
        end
    end

    assign irq_d = done_d & irq_en_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mux_q     <= 1'b0;
            dir_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            run_src_q <= '0;
            run_dst_q <= '0;
            run_len_q <= '0;
            run_dir_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            mux_q     <= mux_d;
            dir_q     <= dir_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            run_src_q <= run_src_d;
            run_dst_q <= run_dst_d;
            run_len_q <= run_len_d;
            run_dir_q <= run_dir_d;
            idx_q     <= idx_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_USER_REGS; gi++) begin : g_user
            logic [USER_REG_WIDTH-1:0] user_q, user_d;
            always_comb begin
                user_d = user_q;
                if (wr_en && widx == 6'(USER0 + gi))
                    user_d = USER_REG_WIDTH'(merge(32'(user_q), reg_wdata_i, reg_wstrb_i));
            end
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) user_q <= '0;
                else       user_q <= user_d;
            end
            assign user_regs_o[gi*USER_REG_WIDTH +: USER_REG_WIDTH] = user_q;
        end
    endgenerate

`ifdef CIM_CTRL_SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
    always_comb begin
        perf_d = perf_q;
        if (start_ok)                         perf_d = 32'd0;
        else if (busy && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) perf_q <= '0;
        else       perf_q <= perf_d;
    end
`endif

    logic mapped;
    always_comb begin
        reg_rdata_o = '0;
        mapped      = 1'b1;
        case (widx)
            W_CTRL:   reg_rdata_o = {28'd0, irq_en_q, dir_q, mux_q, 1'b0};
            W_STATUS: reg_rdata_o = {29'd0, err_q, done_q, busy};
            W_SRC:    reg_rdata_o = 32'(src_q);
            W_DST:    reg_rdata_o = 32'(dst_q);
            W_LEN:    reg_rdata_o = {16'd0, len_q};
`ifdef CIM_CTRL_SEQ_PERF_CNT_EN
            6'h10:    reg_rdata_o = perf_q;
`endif
            default:  mapped = 1'b0;
        endcase
        for (int i = 0; i < NUM_USER_REGS; i++) begin
            if (widx == 6'(USER0 + i)) begin
                reg_rdata_o = 32'(user_regs_o[i*USER_REG_WIDTH +: USER_REG_WIDTH]);
                mapped      = 1'b1;
            end
        end
    end

    assign reg_error_o = reg_valid_i & ~mapped;
    assign reg_ready_o = 1'b1;
    assign mem_mux_o   = mux_q;
    assign irq_o       = irq_q;

endmodule
